// File: rtl/fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_if
// Purpose : bundles the request, strobe, pointer and status signals of the
//           synchronous FIFO sequencing controller into one connection.
// Optional: FIFO_ERR_CNT_EN adds the 8-bit saturating err_cnt signal.
// Signals :
//   wr_en, rd_en        requests from the FIFO user (level, sampled per clk)
//   mem_we, mem_re      storage write/read strobes (combinational)
//   wr_addr, rd_addr    tail/head pointers (registered, AW bits)
//   state               registered 3-bit op state
//   data_count          registered occupancy 0..DEPTH (CW bits)
//   err_cnt             saturating error count (FIFO_ERR_CNT_EN only)
// Modports:
//   master  the requester/observer side (drives wr_en/rd_en)
//   slave   the controller side (drives everything else)
// ---------------------------------------------------------------------------
interface fifo_ctrl_if #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
);
   logic          wr_en;
   logic          rd_en;
   logic          mem_we;
   logic          mem_re;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [2:0]    state;
   logic [CW-1:0] data_count;
`ifdef FIFO_ERR_CNT_EN
   logic [7:0]    err_cnt;

   modport master (
      output wr_en, rd_en,
      input  mem_we, mem_re, wr_addr, rd_addr, state, data_count, err_cnt
   );

   modport slave (
      input  wr_en, rd_en,
      output mem_we, mem_re, wr_addr, rd_addr, state, data_count, err_cnt
   );
`else
   modport master (
      output wr_en, rd_en,
      input  mem_we, mem_re, wr_addr, rd_addr, state, data_count
   );

   modport slave (
      input  wr_en, rd_en,
      output mem_we, mem_re, wr_addr, rd_addr, state, data_count
   );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
// Purpose : sequencing controller for the synchronous FIFO. Owns the head and
//           tail pointers and the occupancy counter, issues zero-latency
//           write/read strobes to the storage array and publishes the op
//           state and occupancy for the flag decoder.
// Optional: define FIFO_ERR_CNT_EN to add an 8-bit saturating count of
//           rejected operations (write when full, read when empty).
// Ports   :
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      fifo_ctrl_if.slave
//              wr_en/rd_en in, mem_we/mem_re out (combinational),
//              wr_addr/rd_addr/state/data_count out (registered),
//              err_cnt out (FIFO_ERR_CNT_EN only)
// State encoding: INIT=000 NO_OP=001 WRITE=010 WR_ERROR=011 READ=100
//                 RD_ERROR=101
// ---------------------------------------------------------------------------
module fifo_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic         clk,
   input  logic         reset_n,
   fifo_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      INIT     = 3'b000,
      NO_OP    = 3'b001,
      WRITE    = 3'b010,
      WR_ERROR = 3'b011,
      READ     = 3'b100,
      RD_ERROR = 3'b101
   } op_state_t;

   op_state_t     state_q;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic wr_only;
   logic rd_only;
   logic not_full;
   logic not_empty;
   logic do_write;
   logic do_read;

   // Request decode. Simultaneous write and read is treated as a no-op, so
   // only exclusive requests can move a pointer.
   always_comb begin
      wr_only   = bus.wr_en & ~bus.rd_en;
      rd_only   = bus.rd_en & ~bus.wr_en;
      not_full  = (count < CW'(DEPTH));
      not_empty = (count != '0);
      do_write  = wr_only & not_full;
      do_read   = rd_only & not_empty;
   end

   // Strobes go straight to storage in the request cycle. Gating with reset_n
   // keeps a held wr_en from writing storage while the controller is in reset.
   assign bus.mem_we = do_write & reset_n;
   assign bus.mem_re = do_read  & reset_n;

   // Single state/datapath register: each edge classifies the request, then
   // moves at most one pointer and adjusts the occupancy on the same edge.
   // Pointers wrap naturally at AW bits since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (do_write) begin
            state_q <= WRITE;
            wr_ptr  <= wr_ptr + AW'(1);
            count   <= count + CW'(1);
         end else if (wr_only) begin
            state_q <= WR_ERROR;
         end else if (do_read) begin
            state_q <= READ;
            rd_ptr  <= rd_ptr + AW'(1);
            count   <= count - CW'(1);
         end else if (rd_only) begin
            state_q <= RD_ERROR;
         end else begin
            state_q <= NO_OP;
         end
      end
   end

   assign bus.state      = state_q;
   assign bus.wr_addr    = wr_ptr;
   assign bus.rd_addr    = rd_ptr;
   assign bus.data_count = count;

`ifdef FIFO_ERR_CNT_EN
   logic [7:0] err_q;

   // Every rejected request (write while full, read while empty) bumps the
   // error count; it sticks at 255 until the next reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= '0;
      end else if (((wr_only & ~not_full) | (rd_only & ~not_empty)) && (err_q != 8'hFF)) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign bus.err_cnt = err_q;
`endif

endmodule
